// File: rtl/clk_switch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_switch_ctrl_pkg
//  Purpose  : Shared state encoding and source encoding for the clock-switch
//             sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_switch_ctrl_pkg;

  // Sequencer states; REVERT is only reachable in timeout-enabled builds
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    GATE   = 3'd2,
    SWITCH = 3'd3,
    SETTLE = 3'd4,
    REVERT = 3'd5
  } state_e;

  // Clock source encoding on sel / cur_src / req_src
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage : clk_switch_ctrl_pkg
`default_nettype wire

// File: rtl/clk_switch_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Single-bit two-flop synchroniser into the clk domain, async
//             active-low reset to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // First stage may go metastable; second stage gives a settled copy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_switch_ctrl
//  Purpose  : Sequencer for a glitch-free two-source clock switch. Gates the
//             downstream clock enable, moves the switch select, waits for the
//             switch's synchronised active flags to confirm, then re-enables.
//  Options  : CLK_SWITCH_CTRL_TIMEOUT_EN - bound the wait for confirmation;
//             on expiry revert sel to the old source and report err.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_switch_ctrl
  import clk_switch_ctrl_pkg::*;
#(
  parameter int unsigned QUIESCE_CYC = 4,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_valid,
  input  logic req_src,
  output logic req_ready,
  input  logic act_A,
  input  logic act_B,
  output logic sel,
  output logic clk_en,
  output logic cur_src,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [CNT_W-1:0] C_QUIESCE_LAST = CNT_W'(QUIESCE_CYC - 1);
  localparam int unsigned      C_CNT_MAX_I    = (QUIESCE_CYC > TIMEOUT_CYC) ? QUIESCE_CYC : TIMEOUT_CYC;
  localparam logic [CNT_W-1:0] C_CNT_MAX      = CNT_W'(C_CNT_MAX_I);
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

  logic       w_sa;
  logic       w_sb;

  state_e     r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic       r_tgt,     w_tgt_nxt;
  logic       r_sel,     w_sel_nxt;
  logic       r_clk_en,  w_clk_en_nxt;
  logic       r_cur_src, w_cur_src_nxt;
  logic       r_done,    w_done_nxt;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
  logic       r_err,     w_err_nxt;
  logic       r_fail,    w_fail_nxt;
  logic       w_old_conf;
`endif
  logic       w_tgt_conf;
  logic [CNT_W-1:0] w_cnt_inc;

  sync_2ff u_sync_a (.clk(clk), .rstn(rstn), .d(act_A), .q(w_sa));
  sync_2ff u_sync_b (.clk(clk), .rstn(rstn), .d(act_B), .q(w_sb));

  // Saturating increment keeps the counter from wrapping on a long wait
  assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  // Target branch running and the other branch fully stopped
  assign w_tgt_conf = (w_sb == r_tgt) && (w_sa == ~r_tgt);
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
  assign w_old_conf = (w_sb == r_cur_src) && (w_sa == ~r_cur_src);
`endif

  // State and output registers; reset parks in INIT with the clock gated
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= INIT;
      r_cnt     <= '0;
      r_tgt     <= SRC_A;
      r_sel     <= SRC_A;
      r_clk_en  <= 1'b0;
      r_cur_src <= SRC_A;
      r_done    <= 1'b0;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
      r_err     <= 1'b0;
      r_fail    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tgt     <= w_tgt_nxt;
      r_sel     <= w_sel_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_cur_src <= w_cur_src_nxt;
      r_done    <= w_done_nxt;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
      r_err     <= w_err_nxt;
      r_fail    <= w_fail_nxt;
`endif
    end
  end

  // Next-state and next-output decode; pulses default low each cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tgt_nxt     = r_tgt;
    w_sel_nxt     = r_sel;
    w_clk_en_nxt  = r_clk_en;
    w_cur_src_nxt = r_cur_src;
    w_done_nxt    = 1'b0;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
    w_err_nxt     = 1'b0;
    w_fail_nxt    = r_fail;
`endif
    case (r_state)
      INIT: begin
        w_clk_en_nxt = 1'b0;
        if (w_sa && !w_sb) begin
          w_clk_en_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      IDLE: begin
        if (req_valid) begin
          if (req_src == r_cur_src) begin
            w_done_nxt = 1'b1;
          end else begin
            w_tgt_nxt    = req_src;
            w_clk_en_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_state_nxt  = GATE;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
            w_fail_nxt   = 1'b0;
`endif
          end
        end
      end
      GATE: begin
        if (r_cnt == C_QUIESCE_LAST) begin
          w_sel_nxt   = r_tgt;
          w_cnt_nxt   = '0;
          w_state_nxt = SWITCH;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      SWITCH: begin
        if (w_tgt_conf) begin
          w_cur_src_nxt = r_tgt;
          w_cnt_nxt     = '0;
          w_state_nxt   = SETTLE;
        end
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
        else if (r_cnt == C_TIMEOUT_LAST) begin
          w_sel_nxt   = r_cur_src;
          w_cnt_nxt   = '0;
          w_state_nxt = REVERT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
`endif
      end
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
      REVERT: begin
        if (w_old_conf) begin
          w_cnt_nxt   = '0;
          w_fail_nxt  = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
`endif
      SETTLE: begin
        if (r_cnt == C_QUIESCE_LAST) begin
          w_clk_en_nxt = 1'b1;
          w_state_nxt  = IDLE;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
          w_err_nxt    = r_fail;
          w_done_nxt   = ~r_fail;
`else
          w_done_nxt   = 1'b1;
`endif
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_clk_en_nxt = 1'b0;
        w_state_nxt  = INIT;
      end
    endcase
  end

  assign sel       = r_sel;
  assign clk_en    = r_clk_en;
  assign cur_src   = r_cur_src;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign req_ready = (r_state == IDLE);
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule : clk_switch_ctrl
`default_nettype wire

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequencer for the glitch-free two-source clock switch (clk_A / clk_B → clk_out).
- Runs on an always-on control clock and accepts source-change requests over a valid/ready handshake.
- Gates the downstream clock enable, drives the switch select, confirms completion from the switch's per-domain active flags, then re-enables.
- Reports done or error to the requester.

Parameters:
- QUIESCE_CYC, 4, control-clock cycles clk_en is held low before sel changes and after the switch is confirmed (min 1).
- TIMEOUT_CYC, 256, max cycles to wait for switch confirmation (used only with the optional feature).
- CNT_W, 9, counter width; must hold max(QUIESCE_CYC, TIMEOUT_CYC).

Ports:
- clk  in  1  control clock, always running
- rstn  in  1  reset
- req_valid  in  1  source-change request
- req_src  in  1  requested source: 0 = A, 1 = B
- req_ready  out  1  high only in IDLE
- act_A  in  1  switch status, clk_A branch enabled (asynchronous to clk)
- act_B  in  1  switch status, clk_B branch enabled (asynchronous to clk)
- sel  out  1  select to the clock switch
- clk_en  out  1  downstream clock-gate enable
- cur_src  out  1  currently confirmed source
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse: request completed
- err  out  1  one-cycle pulse: request failed and reverted

Interface (already decided):
- One clock `clk`.
- Reset `rstn` is asynchronous and active-low.

Behaviour:
- Synchronisation: act_A and act_B each pass through a 2-flop synchroniser in the clk domain, giving sA and sB. The FSM uses only sA and sB.
- Reset values: sel=0, clk_en=0, cur_src=0, busy=1, req_ready=0, done=0, err=0. State = INIT, counter = 0.
- States:
  - INIT:
    - clk_en=0.
    - When sA=1 and sB=0: clk_en←1, go to IDLE. No done pulse.
  - IDLE:
    - req_ready=1, busy=0.
    - On req_valid with req_src==cur_src: done pulses next cycle; sel and clk_en unchanged; stay in IDLE.
    - On req_valid with req_src!=cur_src: latch tgt=req_src, clk_en←0, counter←0, go to GATE.
  - GATE:
    - Count QUIESCE_CYC cycles.
    - Then sel←tgt, counter←0, go to SWITCH.
  - SWITCH:
    - Wait until (sB==tgt) and (sA==!tgt), i.e. target branch active and the other inactive.
    - Then cur_src←tgt, counter←0, go to SETTLE.
  - SETTLE:
    - Count QUIESCE_CYC cycles.
    - Then clk_en←1, done pulse, go to IDLE.
- Latency for an accepted change (request accepted at cycle N):
  - clk_en low at N+1.
  - sel toggles at N+1+QUIESCE_CYC.
  - After confirmation is seen on sA/sB (≥2 cycles of synchroniser delay after the switch flags settle): QUIESCE_CYC further cycles, then clk_en=1 and done on the same edge.
- Handshake:
  - A request transfers when req_valid && req_ready.
  - req_valid outside IDLE is ignored; it is not queued.
  - req_src is sampled only at transfer.
- Simultaneous events: a request arriving on the cycle INIT→IDLE is not accepted (req_ready is still 0).
- Invariants:
  - clk_en is never 1 in GATE, SWITCH or SETTLE.
  - sel never changes while clk_en=1.
- Reset mid-operation: state returns to INIT, sel=0, clk_en=0. Any pending request is dropped with no done/err.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro: CLK_SWITCH_CTRL_TIMEOUT_EN.
- Defined:
  - SWITCH counts cycles. If the counter reaches TIMEOUT_CYC without confirmation, sel←cur_src (revert) and go to REVERT.
  - REVERT waits, with no timeout, for the old source confirmed (sB==cur_src, sA==!cur_src).
  - Then go to SETTLE. SETTLE completes with an err pulse instead of done. cur_src stays the old value.
- Undefined:
  - SWITCH waits indefinitely.
  - REVERT state and err logic are absent; err is tied to 0.
  - TIMEOUT_CYC is unused.

Decomposition:
- Package clk_switch_ctrl_pkg:
  - State enum: INIT, IDLE, GATE, SWITCH, SETTLE, REVERT.
  - Source encoding constants: SRC_A=0, SRC_B=1.
- Sub-module sync_2ff (1-bit, async active-low reset to 0), instantiated twice for act_A and act_B.
- FSM, counter and output registers live in clk_switch_ctrl.

Test Plan:
1. Reset release with act_A=1, act_B=0 → clk_en rises ≈3 cycles after rstn deassertion; cur_src=0, sel=0, req_ready=1.
2. Request req_src=1 with a switch model asserting act_B 10 cycles after sel rises → clk_en=0 at N+1; sel=1 at N+5 (QUIESCE_CYC=4); clk_en=1 and a single done pulse 4 cycles after sA/sB confirm; cur_src=1.
3. Request req_src equal to cur_src → done the next cycle; sel and clk_en unchanged throughout.
4. Hold req_valid high during GATE/SWITCH with the opposite req_src → ignored; exactly one done; no second switch.
5. Assert rstn low while in SWITCH with sel=1 → sel=0 and clk_en=0 immediately; INIT is re-entered; no done/err pulses.
6. With CLK_SWITCH_CTRL_TIMEOUT_EN defined and act_B stuck at 0 → after 256 SWITCH cycles sel reverts to 0; once sA=1, wait 4 cycles, then err pulse, clk_en=1, cur_src=0. With the macro undefined → design remains in SWITCH (busy=1) for 1000 cycles.
